// File: rtl/bridge_pingpong_buffer_pkg.sv
// rtl/bridge_pingpong_buffer_pkg.sv - shared types and sizing helpers for the ping-pong bridge buffer
package bridge_buf_pkg;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_LOAD   = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

  function automatic int depth(input int row, input int col);
    return row * col;
  endfunction

  // max(1, clog2(n)) so a single-replay build still has a 1-bit pass index
  function automatic int pass_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_pingpong_buffer_if.sv
// rtl/bridge_pingpong_buffer_if.sv - write/read channel bundle for the ping-pong bridge buffer
interface bridge_pingpong_buffer_if #(
  parameter int DATA_W = 32,
  parameter int PASS_W = 1
);

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_transpose;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_bank_done;
  logic [PASS_W-1:0] rd_pass;
  logic [1:0]        bank_full;

  modport slave (
    input  wr_valid, wr_data, rd_transpose, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last, rd_bank_done, rd_pass, bank_full
  );

  modport master (
    output wr_valid, wr_data, rd_transpose, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last, rd_bank_done, rd_pass, bank_full
  );

endinterface

// File: rtl/bridge_buf_addr_gen.sv
// rtl/bridge_buf_addr_gen.sv - row/col tile walker giving the address of the following beat
module bridge_buf_addr_gen
  import bridge_buf_pkg::*;
#(
  parameter int ROW_BLK = 4,
  parameter int COL_BLK = 4,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic              i_transpose,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic              o_last
);

  localparam int RW = cnt_w(ROW_BLK);
  localparam int CW = cnt_w(COL_BLK);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [RW-1:0] w_row_nxt;
  logic [CW-1:0] w_col_nxt;
  logic          w_row_end;
  logic          w_col_end;

  assign w_row_end = (r_row == RW'(ROW_BLK - 1));
  assign w_col_end = (r_col == CW'(COL_BLK - 1));
  assign o_last    = w_row_end && w_col_end;

  // Transposed walks rows fastest; both orders wrap to (0,0) after the last beat
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (i_transpose) begin
      if (w_row_end) begin
        w_row_nxt = '0;
        w_col_nxt = w_col_end ? '0 : r_col + 1'b1;
      end else begin
        w_row_nxt = r_row + 1'b1;
      end
    end else begin
      if (w_col_end) begin
        w_col_nxt = '0;
        w_row_nxt = w_row_end ? '0 : r_row + 1'b1;
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
    end
  end

  assign o_next_addr = ADDR_W'(32'(w_row_nxt) * 32'(COL_BLK) + 32'(w_col_nxt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
    end
  end

endmodule

// File: rtl/bridge_pingpong_buffer.sv
// rtl/bridge_pingpong_buffer.sv - two-bank tile buffer: fill one bank while replaying the other
// Optional stall counters enabled by BRIDGE_PINGPONG_STALL_CNT_EN.
module bridge_pingpong_buffer
  import bridge_buf_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LANES      = 2,
  parameter int ROW_BLK    = 4,
  parameter int COL_BLK    = 4,
  parameter int NUM_REPLAY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bridge_pingpong_buffer_if.slave bus
`ifdef BRIDGE_PINGPONG_STALL_CNT_EN
  ,
  output logic [31:0]             wr_stall_cnt,
  output logic [31:0]             rd_stall_cnt
`endif
);

  localparam int DEPTH  = depth(ROW_BLK, COL_BLK);
  localparam int DATA_W = LANES * WIDTH;
  localparam int ADDR_W = cnt_w(DEPTH);
  localparam int PASS_W = pass_w(NUM_REPLAY);

  localparam logic [1:0] ST_IDLE   = RD_IDLE;
  localparam logic [1:0] ST_LOAD   = RD_LOAD;
  localparam logic [1:0] ST_STREAM = RD_STREAM;

  logic [DATA_W-1:0] r_mem [2][DEPTH];

  logic              r_wr_ptr;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_rd_ptr;
  logic [1:0]        r_bank_full;
  logic [1:0]        r_state;
  logic              r_transpose;
  logic [PASS_W-1:0] r_pass;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_rd_last;
  logic              w_bank_done;
  logic              w_last;
  logic [ADDR_W-1:0] w_next_addr;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  assign w_wr_ready  = !r_bank_full[r_wr_ptr];
  assign w_wr_fire   = bus.wr_valid && w_wr_ready;
  assign w_rd_fire   = r_rd_valid && bus.rd_ready;
  assign w_rd_last   = r_rd_valid && w_last;
  assign w_bank_done = w_rd_last && (r_pass == PASS_W'(NUM_REPLAY - 1));

  assign bus.wr_ready     = w_wr_ready;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_last      = w_rd_last;
  assign bus.rd_bank_done = w_bank_done;
  assign bus.rd_pass      = r_pass;
  assign bus.bank_full    = r_bank_full;

  // Fill and release always hit different banks, so the two masks never overlap
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_wr_fire && (r_wr_cnt == ADDR_W'(DEPTH - 1))) w_set[r_wr_ptr] = 1'b1;
    if (w_rd_fire && w_bank_done)                      w_clr[r_rd_ptr] = 1'b1;
  end

  bridge_buf_addr_gen #(
    .ROW_BLK (ROW_BLK),
    .COL_BLK (COL_BLK),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (r_state == ST_IDLE),
    .i_advance   (r_state == ST_STREAM && w_rd_fire && !w_bank_done),
    .i_transpose (r_transpose),
    .o_next_addr (w_next_addr),
    .o_last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_ptr][r_wr_cnt] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= 1'b0;
      r_wr_cnt    <= '0;
      r_bank_full <= '0;
    end else begin
      r_bank_full <= (r_bank_full | w_set) & ~w_clr;
      if (w_wr_fire) begin
        if (r_wr_cnt == ADDR_W'(DEPTH - 1)) begin
          r_wr_cnt <= '0;
          r_wr_ptr <= ~r_wr_ptr;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rd_ptr    <= 1'b0;
      r_transpose <= 1'b0;
      r_pass      <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_bank_full[r_rd_ptr]) begin
            r_transpose <= bus.rd_transpose;
            r_pass      <= '0;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_rd_data  <= r_mem[r_rd_ptr][0];
          r_rd_valid <= 1'b1;
          r_state    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_rd_fire) begin
            if (w_bank_done) begin
              r_rd_valid <= 1'b0;
              r_rd_ptr   <= ~r_rd_ptr;
              r_pass     <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_rd_data <= r_mem[r_rd_ptr][w_next_addr];
              if (w_last) r_pass <= r_pass + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRIDGE_PINGPONG_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_stall_cnt <= '0;
      rd_stall_cnt <= '0;
    end else begin
      if (bus.wr_valid && !w_wr_ready && (wr_stall_cnt != 32'hFFFF_FFFF))
        wr_stall_cnt <= wr_stall_cnt + 32'd1;
      if (r_rd_valid && !bus.rd_ready && (rd_stall_cnt != 32'hFFFF_FFFF))
        rd_stall_cnt <= rd_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bridge_pingpong_buffer.sv
// tb/tb_bridge_pingpong_buffer.sv - scoreboard bench for the ping-pong bridge buffer
module tb_bridge_pingpong_buffer;

  localparam int WIDTH      = 16;
  localparam int LANES      = 2;
  localparam int ROW_BLK    = 2;
  localparam int COL_BLK    = 3;
  localparam int NUM_REPLAY = 2;
  localparam int DW         = 32;
  localparam int PW         = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bridge_pingpong_buffer_if #(.DATA_W(DW), .PASS_W(PW)) bus ();

`ifdef BRIDGE_PINGPONG_STALL_CNT_EN
  logic [31:0] wr_stall_cnt;
  logic [31:0] rd_stall_cnt;
`endif

  bridge_pingpong_buffer #(
    .WIDTH      (WIDTH),
    .LANES      (LANES),
    .ROW_BLK    (ROW_BLK),
    .COL_BLK    (COL_BLK),
    .NUM_REPLAY (NUM_REPLAY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRIDGE_PINGPONG_STALL_CNT_EN
    ,
    .wr_stall_cnt (wr_stall_cnt),
    .rd_stall_cnt (rd_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        done;
    logic        pass;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  bit          have_hold = 0;
  logic [31:0] hold_data;
  bit          toggle_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected replay of one 2x3 tile, two passes; transposed order is 0,3,1,4,2,5
  task automatic push_tile(input int base, input bit tr);
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 6; k++) begin
        int a;
        a      = tr ? ((k % 2) * 3 + k / 2) : k;
        e.data = {16'(base + a), 16'(base + a)};
        e.last = (k == 5);
        e.done = (k == 5) && (p == 1);
        e.pass = (p == 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic write_beat(input logic [31:0] d);
    int n;
    bit seen;
    n    = 0;
    seen = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    do begin
      @(negedge clk);
      seen = bus.wr_ready;
      @(posedge clk);
      n++;
    end while (!seen && n < 500);
    #1;
    bus.wr_valid = 1'b0;
    if (!seen) chk("write_timeout", 32'(seen), 32'd1);
  endtask

  task automatic write_tile(input int base);
    for (int i = 0; i < 6; i++) write_beat({16'(base + i), 16'(base + i)});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      have_hold = 0;
    end else begin
      if (have_hold && bus.rd_valid) begin
        n_cmp++;
        if (bus.rd_data !== hold_data) begin
          n_err++;
          $display("FAIL stall_hold: got %h expected %h", bus.rd_data, hold_data);
        end
      end
      have_hold = bus.rd_valid && !bus.rd_ready;
      hold_data = bus.rd_data;
      if (bus.rd_valid && bus.rd_ready) begin
        exp_t act;
        act = {bus.rd_data, bus.rd_last, bus.rd_bank_done, bus.rd_pass};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got data=%h with no beat expected", bus.rd_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL beat%0d: got data=%h last=%b done=%b pass=%b expected data=%h last=%b done=%b pass=%b",
                     n_acc, act.data, act.last, act.done, act.pass, e.data, e.last, e.done, e.pass);
          end
        end
        n_acc++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base_acc;
    bus.wr_valid     = 1'b0;
    bus.wr_data      = '0;
    bus.rd_transpose = 1'b0;
    bus.rd_ready     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_rd_data", bus.rd_data, 32'd0);
    chk("reset_rd_last", 32'(bus.rd_last), 32'd0);
    chk("reset_bank_done", 32'(bus.rd_bank_done), 32'd0);
    chk("reset_rd_pass", 32'(bus.rd_pass), 32'd0);
    chk("reset_bank_full", 32'(bus.bank_full), 32'd0);

    // row-major tile with 2-cycle first-beat latency
    @(posedge clk); #1;
    bus.rd_ready = 1'b1;
    push_tile(0, 1'b0);
    write_tile(0);
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    chk("lat_first_valid", 32'(bus.rd_valid), 32'd1);
    wait_drain(100);

    // transposed tile
    @(posedge clk); #1;
    bus.rd_transpose = 1'b1;
    push_tile(0, 1'b1);
    write_tile(0);
    wait_drain(100);

    // both banks full, then release with writer pending
    @(posedge clk); #1;
    bus.rd_transpose = 1'b0;
    bus.rd_ready     = 1'b0;
    push_tile(16'h100, 1'b0);
    push_tile(16'h200, 1'b0);
    push_tile(16'h300, 1'b0);
    fork
      begin
        write_tile(16'h100);
        write_tile(16'h200);
        write_tile(16'h300);
      end
      begin
        n = 0;
        while (bus.bank_full != 2'b11 && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("both_full", 32'(bus.bank_full), 32'd3);
        chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("full_wr_ready_hold", 32'(bus.wr_ready), 32'd0);
        @(posedge clk); #1;
        bus.rd_ready = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(bus.rd_valid && bus.rd_ready && bus.rd_bank_done) && n < 200);
        chk("release_seen", 32'(bus.rd_bank_done), 32'd1);
        chk("release_cycle_wr_ready", 32'(bus.wr_ready), 32'd0);
        @(negedge clk);
        chk("after_release_wr_ready", 32'(bus.wr_ready), 32'd1);
      end
    join
    wait_drain(200);

    // random consumer back-pressure
    @(posedge clk); #1;
    bus.rd_transpose = 1'b1;
    push_tile(16'h400, 1'b1);
    push_tile(16'h500, 1'b1);
    toggle_en = 1;
    fork
      begin
        while (toggle_en) begin
          @(posedge clk); #1;
          bus.rd_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    write_tile(16'h400);
    write_tile(16'h500);
    wait_drain(600);
    toggle_en = 0;
    @(posedge clk); #2;
    bus.rd_ready = 1'b1;

    // reset in the middle of a pass
    @(posedge clk); #1;
    bus.rd_transpose = 1'b0;
    push_tile(16'h600, 1'b0);
    base_acc = n_acc;
    write_tile(16'h600);
    n = 0;
    while (n_acc < base_acc + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("mid_pass_reached", 32'(n_acc - base_acc), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("arst_rd_data", bus.rd_data, 32'd0);
    chk("arst_rd_last", 32'(bus.rd_last), 32'd0);
    chk("arst_bank_done", 32'(bus.rd_bank_done), 32'd0);
    chk("arst_rd_pass", 32'(bus.rd_pass), 32'd0);
    chk("arst_bank_full", 32'(bus.bank_full), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_bank_full", 32'(bus.bank_full), 32'd0);
    chk("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("post_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    @(posedge clk); #1;
    push_tile(16'h700, 1'b0);
    write_tile(16'h700);
    wait_drain(100);

`ifdef BRIDGE_PINGPONG_STALL_CNT_EN
    @(posedge clk); #1;
    bus.rd_ready = 1'b0;
    push_tile(16'h800, 1'b0);
    write_tile(16'h800);
    n = 0;
    while (!bus.rd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (7) @(posedge clk);
    #1;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    chk("rd_stall_cnt", rd_stall_cnt, 32'd7);
    chk("wr_stall_cnt", wr_stall_cnt, 32'd0);
    wait_drain(100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
